deadtime_gen: RTL and testbench

DEADTIME_GEN -- requirements
Module: deadtime_gen

---
 rtl/deadtime_gen.sv | 94 +++++++++
 tb/tb_deadtime_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/deadtime_gen.sv
// deadtime_gen: complementary half-bridge gate driver with tick-based dead time and minimum on-time.
// Define DEADTIME_FAULT_LATCH_EN to make faults sticky until rst.
module deadtime_gen #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       cmd,
  input  logic       fault,
  input  logic [7:0] dead_cfg,
  input  logic [7:0] min_on_cfg,
  output logic       out_h,
  output logic       out_l,
  output logic       busy,
  output logic       fault_st
);
  typedef enum logic [2:0] {OFF, DEAD_H, ON_H, DEAD_L, ON_L} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, dead, min_on, cnt_dec;
  logic block, z;
`ifdef DEADTIME_FAULT_LATCH_EN
  logic latched;
  assign block = fault | latched;
`else
  assign block = fault;
`endif
  assign dead    = CNT_W'(dead_cfg);
  assign min_on  = CNT_W'(min_on_cfg);
  assign z       = cnt == '0;
  assign cnt_dec = cnt - CNT_W'(tick & ~z);
  always_comb begin
    nxt     = st;
    cnt_nxt = cnt_dec;
    if (block || !en) begin
      nxt     = OFF;
      cnt_nxt = '0;
    end else begin
      case (st)
        OFF: begin
          nxt     = cmd ? DEAD_H : DEAD_L;
          cnt_nxt = dead;
        end
        DEAD_H: if (z) begin
          nxt     = ON_H;
          cnt_nxt = min_on;
        end
        DEAD_L: if (z) begin
          nxt     = ON_L;
          cnt_nxt = min_on;
        end
        ON_H: if (z && !cmd) begin
          nxt     = DEAD_L;
          cnt_nxt = dead;
        end
        ON_L: if (z && cmd) begin
          nxt     = DEAD_H;
          cnt_nxt = dead;
        end
        default: begin
          nxt     = OFF;
          cnt_nxt = '0;
        end
      endcase
    end
  end
  // outputs decode the next state so they are registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= OFF;
      cnt      <= '0;
      out_h    <= 1'b0;
      out_l    <= 1'b0;
      busy     <= 1'b0;
      fault_st <= 1'b0;
`ifdef DEADTIME_FAULT_LATCH_EN
      latched  <= 1'b0;
`endif
    end else begin
      st       <= nxt;
      cnt      <= cnt_nxt;
      out_h    <= nxt == ON_H;
      out_l    <= nxt == ON_L;
      busy     <= nxt == DEAD_H || nxt == DEAD_L;
`ifdef DEADTIME_FAULT_LATCH_EN
      latched  <= latched | fault;
      fault_st <= latched | fault;
`else
      fault_st <= fault;
`endif
    end
  end
endmodule

// File: tb/tb_deadtime_gen.sv
// tb_deadtime_gen: scoreboard bench for deadtime_gen against a tick-counting phase model.
module tb_deadtime_gen;
  logic clk = 1'b0, rst, tick, en, cmd, fault;
  logic [7:0] dead_cfg, min_on_cfg;
  logic out_h, out_l, busy, fault_st;
  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] q[$];

  deadtime_gen dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .cmd(cmd), .fault(fault),
    .dead_cfg(dead_cfg), .min_on_cfg(min_on_cfg),
    .out_h(out_h), .out_l(out_l), .busy(busy), .fault_st(fault_st)
  );

  always #5 clk = ~clk;

  typedef enum {P_OFF, P_DEAD, P_ON} phase_t;
  phase_t phase = P_OFF;
  bit side = 1'b0;
  int seen = 0, req = 0;
  bit fst = 1'b0;
`ifdef DEADTIME_FAULT_LATCH_EN
  bit latch = 1'b0;
`endif

  // phase model: a phase ends at the first edge where the ticks seen since entry reach the requirement
  task automatic model();
    bit blk;
    blk = fault;
`ifdef DEADTIME_FAULT_LATCH_EN
    blk = fault | latch;
`endif
    if (rst) begin
      phase = P_OFF; seen = 0; req = 0; fst = 1'b0;
`ifdef DEADTIME_FAULT_LATCH_EN
      latch = 1'b0;
`endif
    end else begin
`ifdef DEADTIME_FAULT_LATCH_EN
      latch = latch | fault;
      fst = latch;
`else
      fst = fault;
`endif
      if (blk || !en) phase = P_OFF;
      else if (phase == P_OFF) begin
        phase = P_DEAD; side = cmd; req = int'(dead_cfg); seen = 0;
      end else if (phase == P_DEAD) begin
        if (seen >= req) begin phase = P_ON; req = int'(min_on_cfg); seen = 0; end
        else seen += int'(tick);
      end else begin
        if (seen >= req && cmd != side) begin phase = P_DEAD; side = cmd; req = int'(dead_cfg); seen = 0; end
        else seen += int'(tick);
      end
    end
    q.push_back({phase == P_ON && side, phase == P_ON && !side, phase == P_DEAD, fst});
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit f, input bit t);
    rst = r; en = e; cmd = c; fault = f; tick = t;
    model();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() != 0) begin
      logic [3:0] e;
      e = q.pop_front();
      checks++;
      if ({out_h, out_l, busy, fault_st} !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got h,l,busy,fault_st=%b expected %b", cyc, {out_h, out_l, busy, fault_st}, e);
      end
      checks++;
      if (out_h && out_l) begin
        errors++;
        $display("FAIL overlap cycle %0d: got out_h=1 out_l=1 expected not both", cyc);
      end
    end
  end

  initial begin
    bit c;
    rst = 1'b1; en = 1'b0; cmd = 1'b0; fault = 1'b0; tick = 1'b0;
    dead_cfg = 8'd3; min_on_cfg = 8'd5;
    @(negedge clk);
    repeat (3) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 1, 0, i % 4 == 0);
    for (int i = 0; i < 80; i++) step(0, 1, i < 1 ? 1'b1 : 1'b0, 0, i % 4 == 0);
    dead_cfg = 8'd0; min_on_cfg = 8'd2;
    for (int i = 0; i < 200; i++) step(0, 1, (i / 20) % 2 == 1, 0, i % 3 == 0);
    dead_cfg = 8'd2; min_on_cfg = 8'd1;
    for (int i = 0; i < 80; i++) step(0, 1, 0, i == 40, i % 2 == 0);
    repeat (2) step(1, 0, 0, 0, 0);
    dead_cfg = 8'd5;
    for (int i = 0; i < 60; i++) step(0, i != 4, 1, 0, i % 2 == 0);
    for (int i = 0; i < 40; i++) step(i == 30, 1, 1, 0, 1);
    c = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        dead_cfg = 8'($urandom_range(0, 6));
        min_on_cfg = 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 9) == 0) c = ~c;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) != 0, c,
           $urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
